nms_score_writer: RTL and testbench

//   Write side of the FAST9 score memory: accepts per-pixel corner scores in raster

---
 rtl/fast9_pkg.sv | 40 ++++
 rtl/nms_score_writer_if.sv | 39 +++
 rtl/score_wr_fifo.sv | 53 +++++
 rtl/nms_score_writer.sv | 142 ++++++++++++++
 tb/tb_nms_score_writer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fast9_pkg.sv
// Shared definitions for the FAST9 score-memory write path.
// Provides the frame geometry, score/address types, the writer FSM state
// encoding, the buffer entry layout and a border-classification helper.
// The helper is only referenced when NMS_BORDER_ZERO_EN is defined.
package fast9_pkg;

  localparam int COLUMNS   = 180;
  localparam int ROWS      = 120;
  localparam int ADDR_W    = 15;
  localparam int SCORE_W   = 8;
  localparam int PIX_COUNT = COLUMNS * ROWS;
  // FAST circle radius; pixels this close to any edge have no valid score.
  localparam int BORDER    = 3;

  localparam int COL_W = $clog2(COLUMNS);
  localparam int ROW_W = $clog2(ROWS);

  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [ROW_W-1:0]   row_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } wr_state_t;

  typedef struct packed {
    addr_t  addr;
    score_t score;
  } wr_entry_t;

  function automatic logic is_border(input col_t col, input row_t row);
    return (col < col_t'(BORDER)) || (col >= col_t'(COLUMNS - BORDER)) ||
           (row < row_t'(BORDER)) || (row >= row_t'(ROWS - BORDER));
  endfunction

endpackage

// File: rtl/nms_score_writer_if.sv
// Score stream and score-memory write port of the FAST9 score writer.
//   in_valid / in_ready / in_score : raster-order score stream (valid/ready)
//   mem_busy                       : memory port currently owned by the NMS reader
//   wr_en / wr_addr / wr_data      : score memory write port
// Modports:
//   master : the surrounding system (score producer + memory port arbiter)
//   slave  : the score writer
interface nms_score_writer_if;
  import fast9_pkg::*;

  logic   in_valid;
  logic   in_ready;
  score_t in_score;
  logic   mem_busy;
  logic   wr_en;
  addr_t  wr_addr;
  score_t wr_data;

  modport master (
    output in_valid,
    output in_score,
    output mem_busy,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_score,
    input  mem_busy,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/score_wr_fifo.sv
// Two-entry FIFO holding pending score-memory writes ({addr, score}).
// Ports:
//   clk, reset : clock, synchronous active-high reset (flushes all entries)
//   push       : write push_data into the tail (ignored when full and not popping)
//   push_data  : entry to enqueue
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, valid when count != 0
//   count      : number of stored entries (0..2)
module score_wr_fifo
  import fast9_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wr_entry_t push_data,
  input  logic      pop,
  output wr_entry_t head,
  output logic [1:0] count
);

  wr_entry_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      do_push;
  logic      do_pop;

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nms_score_writer.sv
// Write side of the FAST9 score memory. Accepts per-pixel corner scores in
// raster order and issues one score-memory write per pixel, stalling behind a
// two-entry buffer while the NMS reader owns the shared memory port.
// Pulses done once all COLUMNS*ROWS pixels of a frame have been written.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset; aborts a frame and flushes the buffer
//   start : frame start pulse, only honoured in IDLE
//   bus   : nms_score_writer_if.slave (score stream in, memory write port out)
//   busy  : high while a frame is streaming or draining
//   done  : one-cycle pulse after the last pixel of the frame was written
// Configuration macro:
//   NMS_BORDER_ZERO_EN : when defined, pixels within BORDER of any image edge
//                        are written with score 0 instead of in_score.
module nms_score_writer
  import fast9_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  nms_score_writer_if.slave   bus,
  output logic                busy,
  output logic                done
);

  wr_state_t  state;
  wr_state_t  state_next;
  col_t       col;
  row_t       row;
  addr_t      pix_addr;
  addr_t      last_addr;
  score_t     last_data;

  wr_entry_t  push_data;
  wr_entry_t  head;
  logic [1:0] count;
  logic       in_ready;
  logic       accept;
  logic       wr_en;
  logic       last_pix;
  score_t     cap_score;

  // in_ready looks only at the registered occupancy, so a full buffer never
  // accepts even when it is being drained in the same cycle.
  assign in_ready = (state == STREAM) && (count < 2'd2);
  assign accept   = bus.in_valid & in_ready;
  assign wr_en    = (count != 2'd0) & ~bus.mem_busy;
  assign last_pix = (pix_addr == addr_t'(PIX_COUNT - 1));

`ifdef NMS_BORDER_ZERO_EN
  // Edge pixels are forced to zero so NMS 3x3 windows at the edges read zeros.
  assign cap_score = is_border(col, row) ? '0 : bus.in_score;
`else
  assign cap_score = bus.in_score;
`endif

  assign push_data.addr  = pix_addr;
  assign push_data.score = cap_score;

  score_wr_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (wr_en),
    .head      (head),
    .count     (count)
  );

  // Between writes the port keeps presenting the last written entry.
  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_en ? head.addr  : last_addr;
  assign bus.wr_data  = wr_en ? head.score : last_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        if (accept && last_pix) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave as soon as the final entry is being written, so done follows
        // the last write by exactly one cycle.
        if ((count == 2'd0) || ((count == 2'd1) && wr_en)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster position; pix_addr advances by one per accept and is never derived
  // from row*COLUMNS.
  always_ff @(posedge clk) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      pix_addr <= '0;
    end else if ((state == IDLE) && start) begin
      col      <= '0;
      row      <= '0;
      pix_addr <= '0;
    end else if (accept) begin
      pix_addr <= pix_addr + addr_t'(1);
      if (col == col_t'(COLUMNS - 1)) begin
        col <= '0;
        row <= row + row_t'(1);
      end else begin
        col <= col + col_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr <= '0;
      last_data <= '0;
    end else if (wr_en) begin
      last_addr <= head.addr;
      last_data <= head.score;
    end
  end

endmodule

// File: tb/tb_nms_score_writer.sv
// Self-checking bench for nms_score_writer: a negedge monitor pops an
// expected-write queue filled on every accepted pixel; scenario tasks add
// their own checks on handshake, stall, reset and frame completion.
`timescale 1ns/1ps
module tb_nms_score_writer;
  import fast9_pkg::*;

  typedef struct packed {
    addr_t  a;
    score_t s;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  nms_score_writer_if bus();

  nms_score_writer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  exp_t   sb[$];
  int     exp_addr;
  int     wr_count;
  int     acc_count;
  int     last_wr_addr;
  int     last_wr_cyc;
  int     first_wr_cyc;
  int     first_acc_cyc;
  int     first_wr_addr;
  addr_t  hold_addr;
  score_t hold_data;
  score_t img [PIX_COUNT];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic score_t model_score(input int a, input score_t s);
`ifdef NMS_BORDER_ZERO_EN
    int c;
    int r;
    c = a % COLUMNS;
    r = a / COLUMNS;
    if (c < 3 || c >= COLUMNS - 3 || r < 3 || r >= ROWS - 3) return 8'h00;
`endif
    return s;
  endfunction

  // Scoreboard monitor: every write must match the oldest accepted pixel.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      total++;
      if (bus.wr_en) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_write: unexpected write addr=%0d data=%0h, expected no write",
                   bus.wr_addr, bus.wr_data);
        end else begin
          e = sb.pop_front();
          if (bus.wr_addr !== e.a || bus.wr_data !== e.s) begin
            bad++;
            $display("FAIL sb_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                     bus.wr_addr, bus.wr_data, e.a, e.s);
          end
        end
        if (first_wr_cyc < 0) begin
          first_wr_cyc  = cyc;
          first_wr_addr = int'(bus.wr_addr);
        end
        last_wr_cyc  = cyc;
        last_wr_addr = int'(bus.wr_addr);
        wr_count++;
        if (int'(bus.wr_addr) < PIX_COUNT) img[bus.wr_addr] = bus.wr_data;
        hold_addr = bus.wr_addr;
        hold_data = bus.wr_data;
      end else if (bus.wr_addr !== hold_addr || bus.wr_data !== hold_data) begin
        bad++;
        $display("FAIL wr_hold: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                 bus.wr_addr, bus.wr_data, hold_addr, hold_data);
      end
      if (bus.in_valid && bus.in_ready) begin
        e.a = addr_t'(exp_addr);
        e.s = model_score(exp_addr, bus.in_score);
        sb.push_back(e);
        exp_addr++;
        acc_count++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic frame_clear();
    sb.delete();
    exp_addr      = 0;
    wr_count      = 0;
    acc_count     = 0;
    last_wr_addr  = -1;
    last_wr_cyc   = -1;
    first_wr_cyc  = -1;
    first_acc_cyc = -1;
    first_wr_addr = -1;
  endtask

  task automatic do_reset();
    tick();
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_busy = 1'b0;
    bus.in_score = '0;
    repeat (2) tick();
    frame_clear();
    hold_addr = '0;
    hold_data = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic valid, input score_t score);
    tick();
    start        = 1'b1;
    bus.in_valid = valid;
    bus.in_score = score;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.mem_busy = 1'b0;
    bus.in_score = 8'h5A;
    repeat (2) tick();
    sample();
    total += 6;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    if (bus.wr_en !== 1'b0)    begin bad++; $display("FAIL rst_wr_en: got %b expected 0", bus.wr_en); end
    if (bus.wr_addr !== '0)    begin bad++; $display("FAIL rst_wr_addr: got %0d expected 0", bus.wr_addr); end
    if (bus.wr_data !== '0)    begin bad++; $display("FAIL rst_wr_data: got %0h expected 0", bus.wr_data); end
    if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)         begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
    frame_clear();
    hold_addr = '0;
    hold_data = '0;
    tick();
    reset = 1'b0;
    sample();
    total += 2;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready: got %b expected 0", bus.in_ready); end
    if (busy !== 1'b0)         begin bad++; $display("FAIL idle_busy: got %b expected 0", busy); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    bit got;
    got = 1'b0;
    frame_clear();
    start_frame(1'b1, score_t'($urandom));
    sample();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ff_busy: got %b expected 1", busy); end
    for (int i = 0; i < 30000 && !got; i++) begin
      tick();
      bus.in_score = score_t'($urandom);
      sample();
      if (done === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ff_done_timeout: got no done, expected done within 30000 cycles");
    end else begin
      total += 5;
      if (wr_count !== PIX_COUNT) begin bad++; $display("FAIL ff_wr_count: got %0d expected %0d", wr_count, PIX_COUNT); end
      if (cyc - last_wr_cyc !== 1) begin bad++; $display("FAIL ff_done_lat: got %0d expected 1", cyc - last_wr_cyc); end
      if (sb.size() !== 0) begin bad++; $display("FAIL ff_sb_empty: got %0d expected 0", sb.size()); end
      if (first_wr_cyc - first_acc_cyc !== 1) begin
        bad++; $display("FAIL ff_min_lat: got %0d expected 1", first_wr_cyc - first_acc_cyc);
      end
      if (last_wr_addr !== PIX_COUNT - 1) begin
        bad++; $display("FAIL ff_last_addr: got %0d expected %0d", last_wr_addr, PIX_COUNT - 1);
      end
    end
    tick();
    bus.in_valid = 1'b0;
    sample();
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL ff_busy_after: got %b expected 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL ff_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_stall_border();
    int acc0;
    int wr0;
    int nxt;
    bit got;
    score_t want;
    got = 1'b0;
    frame_clear();
    start_frame(1'b1, 8'hFF);
    for (int i = 0; i < 2000 && acc_count < 1000; i++) begin
      tick();
      sample();
    end
    tick();
    bus.mem_busy = 1'b1;
    acc0 = acc_count;
    wr0  = wr_count;
    nxt  = last_wr_addr + 1;
    for (int i = 0; i < 10; i++) begin
      sample();
      total++;
      if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL stall_wr_en: cycle %0d got %b expected 0", i, bus.wr_en); end
      tick();
    end
    total += 4;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready); end
    if (sb.size() !== 2) begin bad++; $display("FAIL stall_pending: got %0d expected 2", sb.size()); end
    if (wr_count !== wr0) begin bad++; $display("FAIL stall_writes: got %0d expected %0d", wr_count, wr0); end
    if (acc_count - acc0 > 2) begin bad++; $display("FAIL stall_accepts: got %0d expected <=2", acc_count - acc0); end
    bus.mem_busy = 1'b0;
    sample();
    total++;
    if (bus.wr_en !== 1'b1 || int'(bus.wr_addr) !== nxt) begin
      bad++;
      $display("FAIL stall_resume: got wr_en=%b addr=%0d expected wr_en=1 addr=%0d", bus.wr_en, bus.wr_addr, nxt);
    end
    for (int i = 0; i < 25000 && !got; i++) begin
      tick();
      sample();
      if (done === 1'b1) got = 1'b1;
    end
    total++;
    if (!got || wr_count !== PIX_COUNT) begin
      bad++;
      $display("FAIL stall_frame: got done=%b writes=%0d expected done=1 writes=%0d", got, wr_count, PIX_COUNT);
    end
`ifdef NMS_BORDER_ZERO_EN
    want = 8'h00;
`else
    want = 8'hFF;
`endif
    total += 4;
    if (img[0] !== want)     begin bad++; $display("FAIL border_0: got %0h expected %0h", img[0], want); end
    if (img[182] !== want)   begin bad++; $display("FAIL border_182: got %0h expected %0h", img[182], want); end
    if (img[21599] !== want) begin bad++; $display("FAIL border_21599: got %0h expected %0h", img[21599], want); end
    if (img[543] !== 8'hFF)  begin bad++; $display("FAIL inner_543: got %0h expected ff", img[543]); end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_random();
    frame_clear();
    start_frame(1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.mem_busy = ($urandom_range(0, 3) == 0);
      bus.in_score = score_t'($urandom);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.mem_busy = 1'b0;
    repeat (4) tick();
    sample();
    total += 3;
    if (acc_count < 100) begin bad++; $display("FAIL rnd_accepts: got %0d expected >=100", acc_count); end
    if (wr_count !== acc_count) begin bad++; $display("FAIL rnd_drained: got %0d writes expected %0d", wr_count, acc_count); end
    if (last_wr_addr !== acc_count - 1) begin
      bad++; $display("FAIL rnd_last_addr: got %0d expected %0d", last_wr_addr, acc_count - 1);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    frame_clear();
    start_frame(1'b1, score_t'($urandom));
    for (int i = 0; i < 6000 && acc_count < 5000; i++) begin
      tick();
      bus.in_score = score_t'($urandom);
      sample();
    end
    tick();
    bus.mem_busy = 1'b1;
    repeat (2) tick();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      sample();
      total++;
      if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL rstmid_stale: got wr_en=%b addr=%0d expected no write", bus.wr_en, bus.wr_addr); end
      tick();
    end
    start_frame(1'b1, score_t'($urandom));
    for (int i = 0; i < 200 && wr_count < 50; i++) begin
      tick();
      bus.in_score = score_t'($urandom);
      sample();
    end
    total += 2;
    if (first_wr_addr !== 0) begin bad++; $display("FAIL rstmid_first_addr: got %0d expected 0", first_wr_addr); end
    if (wr_count < 50) begin bad++; $display("FAIL rstmid_progress: got %0d writes expected >=50", wr_count); end
    do_reset();
  endtask

  task automatic test_start_ignored();
    frame_clear();
    start_frame(1'b1, 8'h11);
    for (int i = 0; i < 400 && acc_count < 300; i++) begin
      tick();
      bus.in_score = score_t'($urandom);
      sample();
    end
    tick();
    start = 1'b1;
    sample();
    total += 2;
    if (busy !== 1'b1)         begin bad++; $display("FAIL stign_busy: got %b expected 1", busy); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stign_in_ready: got %b expected 1", bus.in_ready); end
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && acc_count < 600; i++) begin
      tick();
      bus.in_score = score_t'($urandom);
      sample();
    end
    total += 2;
    if (last_wr_addr !== wr_count - 1) begin
      bad++; $display("FAIL stign_addr: got %0d expected %0d", last_wr_addr, wr_count - 1);
    end
    if (wr_count < 590) begin bad++; $display("FAIL stign_progress: got %0d writes expected >=590", wr_count); end
    do_reset();
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.mem_busy = 1'b0;
    bus.in_score = '0;
    frame_clear();
    hold_addr = '0;
    hold_data = '0;
    test_reset();
    test_full_frame();
    test_stall_border();
    test_random();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
